gcd_requester: RTL and testbench
================================

Name: gcd_requester

Overview:
- Initiator side of the GCD core's go/done interface.
- Accepts operand pairs on a valid/ready request port and drives the GCD core's in1/in2/go.
- Waits for done, captures the core's result, and returns it on a valid/ready response port.
- Adds a zero-operand shortcut and a timeout, so a hung core cannot stall the system.

Parameters:
- WIDTH, 32, operand/result width; must match the GCD core.
- TIMEOUT, 1024, max cycles in RUN before aborting; must be ≥1.
- CNT_W, 16, timeout counter width; 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request operands valid.
- req_ready  output  1  block can accept a request.
- req_a  input  WIDTH  first operand.
- req_b  input  WIDTH  second operand.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  GCD result, or 0 on error.
- rsp_err  output  1  1 = timeout abort.
- gcd_in1  output  WIDTH  to core in1, registered.
- gcd_in2  output  WIDTH  to core in2, registered.
- gcd_go  output  1  to core go, registered.
- gcd_out  input  WIDTH  from core out.
- gcd_done  input  1  from core done.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - gcd_in1=0, gcd_in2=0, gcd_go=0.
  - busy=0, timeout counter=0.
- Reset asserted mid-operation aborts immediately. No response is produced for the in-flight request, and gcd_go drops asynchronously.
- FSM states:
  - IDLE: req_ready=1 is combinational from state, all other outputs inactive.
    - On req_valid&&req_ready, latch req_a→gcd_in1 and req_b→gcd_in2.
    - If req_a==0 or req_b==0, set rsp_data = req_a|req_b (gcd(0,0)=0), rsp_err=0, and go to RESP. The core is never started.
    - Otherwise set gcd_go=1, counter=0, and go to RUN.
  - RUN: gcd_go held 1 and gcd_in1/gcd_in2 held stable; counter increments each cycle.
    - On the first cycle with gcd_done=1: rsp_data←gcd_out, rsp_err=0, gcd_go←0, go to DRAIN.
    - Else if counter==TIMEOUT-1: rsp_data←0, rsp_err←1, gcd_go←0, go to DRAIN.
    - If done and timeout occur on the same cycle, done wins.
  - DRAIN: gcd_go=0. Stay at least one cycle, until gcd_done==0, then go to RESP.
    - DRAIN has no exit timeout. On the error path, leaving DRAIN needs the core to drop done; a core stuck with done=1 requires rst.
  - RESP: rsp_valid=1; rsp_data and rsp_err stable while rsp_valid=1 && !rsp_ready.
    - On rsp_ready, go to IDLE next cycle with rsp_valid=0.
- Latency (normal path): acceptance edge → gcd_go=1 next cycle. Core done seen at cycle k of RUN → rsp_valid rises 2 cycles later at the earliest (1 DRAIN cycle).
- Zero-operand path: rsp_valid asserts on the cycle after acceptance.
- Throughput: one request in flight, with no pipelining. req_ready=0 in RUN, DRAIN and RESP. Back-to-back requests always see gcd_go low for ≥2 cycles between launches.
- gcd_out is sampled only in RUN on the done cycle; its value at any other time is ignored.
- The block does not interpret gcd_out; it passes the core's result through unchanged (WIDTH bits, no arithmetic).

Test Plan:
- Nominal: with a real GCD core, send a=21, b=3 → gcd_go pulses and rsp_data=3, rsp_err=0. Then a=40, b=5 → rsp_data=5; gcd_go is low ≥2 cycles between the two runs.
- Zero shortcut: a=0, b=18 → rsp_valid on the next cycle with rsp_data=18 and gcd_go never asserted. Then a=0, b=0 → rsp_data=0.
- Backpressure: a=48, b=36, rsp_ready held 0 for 10 cycles → rsp_valid stays 1 with rsp_data=12 stable and req_ready=0 throughout. Releasing rsp_ready → IDLE, req_ready=1.
- Timeout: stub core with gcd_done tied 0, TIMEOUT=8, a=7, b=5 → gcd_go high exactly 8 cycles, then rsp_err=1, rsp_data=0.
- Done/timeout tie and slow drain: stub asserts done on counter==TIMEOUT-1 with out=9 and holds done 3 extra cycles → rsp_data=9, rsp_err=0, and rsp_valid only after done falls.
- Reset mid-RUN: assert rst while in RUN → gcd_go=0, busy=0 and req_ready=1 immediately, with no rsp_valid. A following request a=100, b=75 → rsp_data=25.

Source files
------------

// File: rtl/gcd_requester.sv
// Initiator for a go/done GCD core. It takes operand pairs on a valid/ready port
// and returns the core result, with a zero-operand shortcut and a RUN timeout.
module gcd_requester #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] gcd_in1,
  output logic [WIDTH-1:0] gcd_in2,
  output logic             gcd_go,
  input  logic [WIDTH-1:0] gcd_out,
  input  logic             gcd_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             go_q;

  logic             req_fire_c;
  logic             zero_op_c;
  logic             timeout_hit_c;

  assign req_fire_c    = req_valid && (state_q == S_IDLE);
  assign zero_op_c     = (req_a == '0) || (req_b == '0);
  assign timeout_hit_c = (cnt_q == CNT_LAST);

  // Sequencer: launch, wait for done or timeout, drain done, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire_c) begin
            in1_q <= req_a;
            in2_q <= req_b;
            cnt_q <= '0;
            if (zero_op_c) begin
              // gcd(x,0)=x and gcd(0,0)=0, so the OR is the answer
              rsp_data_q  <= req_a | req_b;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              go_q    <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (gcd_done) begin
            rsp_data_q <= gcd_out;
            rsp_err_q  <= 1'b0;
            go_q       <= 1'b0;
            state_q    <= S_DRAIN;
          end else if (timeout_hit_c) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            go_q       <= 1'b0;
            state_q    <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (!gcd_done) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          go_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign gcd_in1   = in1_q;
  assign gcd_in2   = in2_q;
  assign gcd_go    = go_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Randomized bench for gcd_requester with a scriptable GCD core stub
// (normal, hung, and done-at-timeout-with-slow-drain behaviours).
module tb_gcd_requester;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TO    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] req_a, req_b, rsp_data, gcd_in1, gcd_in2, gcd_out;
  logic             gcd_go, gcd_done, busy;

  int total = 0;
  int bad   = 0;

  gcd_requester #(.WIDTH(WIDTH), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gcd_in1(gcd_in1), .gcd_in2(gcd_in2), .gcd_go(gcd_go),
    .gcd_out(gcd_out), .gcd_done(gcd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core stub. mode 0: done after lat+1 go cycles; 1: never done; 2: done with tie_out.
  int          mode = 0;
  int          lat = 2;
  int          hold_extra = 0;
  logic [31:0] tie_out = 32'd0;
  int          core_cnt, core_hold;
  logic        core_done;
  logic [31:0] core_out;

  assign gcd_done = core_done;
  assign gcd_out  = core_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_done <= 1'b0;
      core_out  <= '0;
      core_cnt  <= 0;
      core_hold <= 0;
    end else if (gcd_go) begin
      core_cnt  <= core_cnt + 1;
      core_hold <= hold_extra;
      if (!core_done) begin
        if (mode != 1 && core_cnt == lat) begin
          core_done <= 1'b1;
          core_out  <= (mode == 2) ? tie_out : ref_gcd(gcd_in1, gcd_in2);
        end else begin
          core_out <= $urandom;
        end
      end
    end else begin
      core_cnt <= 0;
      if (core_done && core_hold > 0) begin
        core_hold <= core_hold - 1;
      end else begin
        core_done <= 1'b0;
        core_out  <= $urandom;
      end
    end
  end

  // Observers: launch count, go-high cycles, min go-low gap, operand stability.
  int          launches = 0;
  int          go_cycles = 0;
  int          low_run = 0;
  int          min_gap = 1000;
  bit          prev_go = 1'b0;
  bit          unstable = 1'b0;
  bit          valid_with_done = 1'b0;
  logic [31:0] p1 = '0, p2 = '0;

  always @(negedge clk) begin
    if (gcd_go) begin
      go_cycles++;
      if (!prev_go) begin
        if (launches > 0 && low_run < min_gap) min_gap = low_run;
        launches++;
      end else if (gcd_in1 !== p1 || gcd_in2 !== p2) begin
        unstable = 1'b1;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    if (rsp_valid && gcd_done) valid_with_done = 1'b1;
    prev_go = gcd_go;
    p1 = gcd_in1;
    p2 = gcd_in2;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    got = rsp_valid;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    obs = {req_ready, busy, rsp_valid, rsp_err, gcd_go};
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl {rdy,busy,vld,err,go} got=%b want=10000", obs);
    end
    total++;
    if (rsp_data !== '0 || gcd_in1 !== '0 || gcd_in2 !== '0) begin
      bad++;
      $display("FAIL reset_data got data=%h in1=%h in2=%h want 0", rsp_data, gcd_in1, gcd_in2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [31:0] av[2] = '{32'd21, 32'd40};
    logic [31:0] bv[2] = '{32'd3, 32'd5};
    logic [31:0] ev[2] = '{32'd3, 32'd5};
    int l0 = launches;
    bit got;
    int cyc;
    mode = 0; lat = 3; hold_extra = 0;
    for (int i = 0; i < 2; i++) begin
      send(av[i], bv[i]);
      total++;
      if ({gcd_go, busy, req_ready} !== 3'b110 || gcd_in1 !== av[i] || gcd_in2 !== bv[i]) begin
        bad++;
        $display("FAIL nominal_launch go/busy/rdy=%b in1=%0d in2=%0d want 110 %0d %0d",
                 {gcd_go, busy, req_ready}, gcd_in1, gcd_in2, av[i], bv[i]);
      end
      wait_rsp(got, cyc);
      total++;
      if (!got || rsp_data !== ev[i] || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL nominal_rsp valid=%0b data=%0d err=%0b want 1 %0d 0", got, rsp_data, rsp_err, ev[i]);
      end
      accept();
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL nominal_idle rdy=%0b valid=%0b want 1 0", req_ready, rsp_valid);
      end
    end
    total++;
    if (launches - l0 != 2 || min_gap < 2 || unstable) begin
      bad++;
      $display("FAIL nominal_go launches=%0d min_gap=%0d unstable=%0b want 2 >=2 0",
               launches - l0, min_gap, unstable);
    end
  endtask

  task automatic test_zero();
    logic [31:0] av[3] = '{32'd0, 32'd0, 32'd29};
    logic [31:0] bv[3] = '{32'd18, 32'd0, 32'd0};
    int l0 = launches;
    for (int i = 0; i < 3; i++) begin
      send(av[i], bv[i]);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== (av[i] | bv[i]) || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL zero_rsp valid=%0b data=%0d err=%0b want 1 %0d 0",
                 rsp_valid, rsp_data, rsp_err, av[i] | bv[i]);
      end
      accept();
    end
    total++;
    if (launches != l0) begin
      bad++;
      $display("FAIL zero_no_go launches=%0d want 0", launches - l0);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    int cyc;
    bit held = 1'b1;
    mode = 0; lat = 1;
    send(32'd48, 32'd36);
    wait_rsp(got, cyc);
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_data !== 32'd12 || rsp_err || req_ready) held = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!got || !held) begin
      bad++;
      $display("FAIL backpressure_hold got=%0b held=%0b data=%0d want 1 1 12", got, held, rsp_data);
    end
    accept();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release rdy=%0b busy=%0b valid=%0b want 1 0 0", req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    bit got;
    int cyc;
    int g0 = go_cycles;
    mode = 1;
    send(32'd7, 32'd5);
    wait_rsp(got, cyc);
    total++;
    if (go_cycles - g0 != int'(TO)) begin
      bad++;
      $display("FAIL timeout_go_len got=%0d want=%0d", go_cycles - g0, TO);
    end
    total++;
    if (!got || rsp_err !== 1'b1 || rsp_data !== '0) begin
      bad++;
      $display("FAIL timeout_rsp valid=%0b err=%0b data=%0d want 1 1 0", got, rsp_err, rsp_data);
    end
    accept();
    mode = 0;
  endtask

  task automatic test_tie();
    bit got;
    int cyc;
    mode = 2; lat = int'(TO) - 2; hold_extra = 3; tie_out = 32'd9;
    send(32'd7, 32'd5);
    wait_rsp(got, cyc);
    total++;
    if (!got || rsp_data !== 32'd9 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL tie_rsp valid=%0b data=%0d err=%0b want 1 9 0", got, rsp_data, rsp_err);
    end
    total++;
    if (valid_with_done || gcd_done !== 1'b0) begin
      bad++;
      $display("FAIL tie_drain valid_with_done=%0b done=%0b want 0 0", valid_with_done, gcd_done);
    end
    accept();
    mode = 0; hold_extra = 0;
  endtask

  task automatic test_reset_mid_run();
    bit got;
    int cyc;
    mode = 1;
    send(32'd12, 32'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({gcd_go, busy, req_ready, rsp_valid} !== 4'b0010) begin
      bad++;
      $display("FAIL midrun_reset go/busy/rdy/vld=%b want 0010", {gcd_go, busy, req_ready, rsp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode = 0; lat = 2;
    send(32'd100, 32'd75);
    wait_rsp(got, cyc);
    total++;
    if (!got || rsp_data !== 32'd25 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL midrun_next valid=%0b data=%0d err=%0b want 1 25 0", got, rsp_data, rsp_err);
    end
    accept();
  endtask

  task automatic test_random();
    bit got;
    int cyc;
    logic [31:0] a, b, g, exp_d;
    logic        exp_e;
    bit          stable;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom; b = $urandom;
      end else begin
        g = $urandom_range(1, 60);
        a = g * $urandom_range(0, 40);
        b = g * $urandom_range(0, 40);
      end
      mode       = ($urandom_range(0, 5) == 0) ? 1 : 0;
      lat        = $urandom_range(0, int'(TO) - 3);
      hold_extra = $urandom_range(0, 2);
      if (a == 0 || b == 0) begin
        exp_d = a | b; exp_e = 1'b0;
      end else if (mode == 1) begin
        exp_d = '0; exp_e = 1'b1;
      end else begin
        exp_d = ref_gcd(a, b); exp_e = 1'b0;
      end
      send(a, b);
      wait_rsp(got, cyc);
      stable = 1'b1;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== exp_d || rsp_err !== exp_e) stable = 1'b0;
      end
      total++;
      if (!got || !stable || rsp_data !== exp_d || rsp_err !== exp_e) begin
        bad++;
        $display("FAIL random_%0d a=%0d b=%0d valid=%0b stable=%0b data=%0d err=%0b want %0d %0b",
                 i, a, b, got, stable, rsp_data, rsp_err, exp_d, exp_e);
      end
      accept();
    end
    mode = 0; hold_extra = 0;
    total++;
    if (min_gap < 2 || unstable || valid_with_done) begin
      bad++;
      $display("FAIL random_protocol min_gap=%0d unstable=%0b valid_with_done=%0b want >=2 0 0",
               min_gap, unstable, valid_with_done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero();
    test_backpressure();
    test_timeout();
    test_tie();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
